tl_sensor_qual: RTL and testbench
=================================

// Module: tl_sensor_qual
// PURPOSE
//  Conditions the two raw vehicle-loop detector inputs into the clean Ta/Tb
//  traffic-present inputs consumed by tl_cntr. It sits directly upstream of
//  tl_cntr, and its Ta/Tb outputs wire straight to tl_cntr's Ta/Tb inputs.
//  Per channel it synchronises, debounces and gap-holds the detector signal,
//  and counts qualified vehicle arrivals for diagnostics.
// PARAMETERS
//  DEB_CYCLES   4   cycles of stable high needed to qualify a vehicle (>=2)
//  HOLD_CYCLES  8   cycles Ta/Tb is held after the detector clears (>=2)
//  CNT_W        8   width of each saturating vehicle counter
// PORTS
//  clk       in   1      system clock, rising edge
//  reset     in   1      synchronous, active-high reset
//  raw_a     in   1      street A loop detector, asynchronous, 1=metal present
//  raw_b     in   1      street B loop detector, asynchronous
//  cnt_clr   in   1      synchronous clear of both vehicle counters
//  Ta        out  1      qualified traffic on street A (drives tl_cntr.Ta)
//  Tb        out  1      qualified traffic on street B (drives tl_cntr.Tb)
//  veh_a     out  CNT_W  street A arrivals, saturating
//  veh_b     out  CNT_W  street B arrivals, saturating
// BEHAVIOUR
//  - Reset (sampled high at an edge): sync flops=0, state=IDLE, cnt=0.
//    Ta=Tb=0 and veh_a=veh_b=0 after that edge. Reset during any state
//    aborts that state immediately.
//  - Each channel uses a 2-flop synchroniser. s is the 2nd flop output.
//  - Per-channel FSM with counter cnt (width clog2(max(DEB,HOLD)+1)):
//    IDLE    T=0; s=1 -> QUAL, cnt=1
//    QUAL    T=0; s=0 -> IDLE, cnt=0
//                 else cnt==DEB_CYCLES -> PRESENT, veh++
//                 else cnt++
//    PRESENT T=1; s=0 -> GAP, cnt=1
//    GAP     T=1; s=1 -> PRESENT (same vehicle, no count)
//                 else cnt==HOLD_CYCLES -> IDLE
//                 else cnt++
//  - T is decoded from the state register only (PRESENT|GAP), so there are
//    no glitches.
//  - Latency: edge 1 is the first edge to sample raw high. Ta goes high after
//    edge DEB_CYCLES+2 if raw stays high. Fall latency uses the same rule with
//    HOLD_CYCLES+2.
//  - A synced pulse shorter than DEB_CYCLES never asserts T and never counts.
//  - A synced gap shorter than HOLD_CYCLES keeps T high and does not count.
//  - Counters: +1 on each QUAL->PRESENT transition, saturating at
//    2**CNT_W-1 (no wrap). cnt_clr has priority over an increment in the same
//    cycle (result 0). Channels A and B are fully independent, so
//    simultaneous events on both are each handled normally.
// STRUCTURE
//  - Package tl_pkg holds typedef enum {IDLE,QUAL,PRESENT,GAP} sq_state_t.
//    This package is shared with tl_cntr's light-code constants.
//  - Sub-module tl_sensor_chan contains one synchroniser, FSM and counter.
//    tl_sensor_qual instantiates it twice (A and B) and holds no other logic.
// TESTING (DEB=4, HOLD=8, CNT_W=8, 10 ns clk)
//  1. Hold reset 3 cycles with raw_a=raw_b=1 -> Ta=Tb=0 and veh=0 during
//     reset. Release reset -> Ta rises 6 edges later.
//  2. raw_a high for 3 cycles -> Ta stays 0, veh_a=0. raw_a high for 4
//     cycles -> Ta=1, veh_a=1.
//  3. Vehicle present, then raw_a low for 5 cycles, then high again -> Ta
//     never drops, veh_a unchanged. Then raw_a low for good -> Ta falls
//     exactly 10 edges after the first low sample.
//  4. raw_a and raw_b rise on the same edge -> Ta and Tb rise on the same
//     edge, and veh_a and veh_b both increment.
//  5. Preload 255 qualified arrivals on A -> veh_a stays 255. Assert cnt_clr
//     on the qualifying edge -> veh_a=0.
//  6. Assert reset while in GAP -> Ta=0 and state=IDLE next edge. After
//     release, raw_a still high -> full DEB re-qualification is required.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared traffic-light definitions: sensor qualifier states and light codes
// used by tl_cntr.
package tl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        QUAL,
        PRESENT,
        GAP
    } sq_state_t;

    localparam logic [1:0] LIGHT_GREEN  = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_RED    = 2'b10;

    // Counter width able to hold the larger of the debounce and hold lengths.
    function automatic int sq_cnt_w(input int deb, input int hold);
        int top;
        top = (deb > hold) ? deb : hold;
        return $clog2(top + 1);
    endfunction

endpackage

// File: rtl/tl_sensor_chan.sv
// One detector channel: 2-flop synchroniser, debounce/gap-hold FSM and a
// saturating arrival counter.
module tl_sensor_chan
    import tl_pkg::*;
#(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             raw,
    input  logic             cnt_clr,
    output logic             t,
    output logic [CNT_W-1:0] veh
);

    localparam int CW = sq_cnt_w(DEB_CYCLES, HOLD_CYCLES);

    // cnt counts samples already seen, so the run completes when the
    // current sample is the last one.
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic            sync1;
    logic            s;
    sq_state_t       state;
    sq_state_t       state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            veh_inc;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no branch
    // can leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        veh_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (s) begin
                    state_nxt = QUAL;
                    cnt_nxt   = CNT_ONE;
                end
            end
            QUAL: begin
                if (!s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = PRESENT;
                    cnt_nxt   = '0;
                    veh_inc   = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            PRESENT: begin
                if (!s) begin
                    state_nxt = GAP;
                    cnt_nxt   = CNT_ONE;
                end
            end
            GAP: begin
                if (s) begin
                    state_nxt = PRESENT;
                    cnt_nxt   = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Clear wins over a same-cycle arrival; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            veh <= '0;
        end else if (veh_inc && (veh != '1)) begin
            veh <= veh + 1'b1;
        end
    end

    assign t = (state == PRESENT) || (state == GAP);

endmodule

// File: rtl/tl_sensor_qual.sv
// Qualifies the street A and B loop detectors into the Ta/Tb inputs of
// tl_cntr; two independent channel instances and nothing else.
module tl_sensor_qual #(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             raw_a,
    input  logic             raw_b,
    input  logic             cnt_clr,
    output logic             Ta,
    output logic             Tb,
    output logic [CNT_W-1:0] veh_a,
    output logic [CNT_W-1:0] veh_b
);

    tl_sensor_chan #(
        .DEB_CYCLES  (DEB_CYCLES),
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_chan_a (
        .clk     (clk),
        .reset   (reset),
        .raw     (raw_a),
        .cnt_clr (cnt_clr),
        .t       (Ta),
        .veh     (veh_a)
    );

    tl_sensor_chan #(
        .DEB_CYCLES  (DEB_CYCLES),
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_chan_b (
        .clk     (clk),
        .reset   (reset),
        .raw     (raw_b),
        .cnt_clr (cnt_clr),
        .t       (Tb),
        .veh     (veh_b)
    );

endmodule

// File: tb/tb_tl_sensor_qual.sv
// Self-checking bench for tl_sensor_qual: per-cycle scoreboard from a
// run-length model plus table-driven end-of-segment expectations.
module tb_tl_sensor_qual;

    localparam int DEB   = 4;
    localparam int HOLD  = 8;
    localparam int CNT_W = 8;
    localparam int VMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             raw_a;
    logic             raw_b;
    logic             cnt_clr;
    logic             Ta;
    logic             Tb;
    logic [CNT_W-1:0] veh_a;
    logic [CNT_W-1:0] veh_b;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    tl_sensor_qual #(
        .DEB_CYCLES  (DEB),
        .HOLD_CYCLES (HOLD),
        .CNT_W       (CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .raw_a   (raw_a),
        .raw_b   (raw_b),
        .cnt_clr (cnt_clr),
        .Ta      (Ta),
        .Tb      (Tb),
        .veh_a   (veh_a),
        .veh_b   (veh_b)
    );

    // Model tracks raw sample history and run lengths of the synced signal.
    typedef struct {
        logic p1;
        logic p2;
        logic t;
        int   hi;
        int   lo;
        int   veh;
    } chan_m_t;

    typedef struct {
        logic ta;
        logic tb;
        int   va;
        int   vb;
    } exp_t;

    typedef struct {
        logic rst;
        logic a;
        logic b;
        logic clr;
        int   n;
        logic ta;
        logic tb;
        int   va;
        int   vb;
    } vec_t;

    chan_m_t ma = '{1'b0, 1'b0, 1'b0, 0, 0, 0};
    chan_m_t mb = '{1'b0, 1'b0, 1'b0, 0, 0, 0};
    exp_t    sb_q[$];
    vec_t    vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_step(inout chan_m_t m, input logic raw,
                                       input logic rst, input logic clr);
        logic s;
        logic inc;
        inc = 1'b0;
        if (rst) begin
            m.p1 = 1'b0; m.p2 = 1'b0; m.t = 1'b0;
            m.hi = 0; m.lo = 0; m.veh = 0;
        end else begin
            s    = m.p2;
            m.p2 = m.p1;
            m.p1 = raw;
            if (!m.t) begin
                m.hi = s ? m.hi + 1 : 0;
                if (m.hi == DEB) begin
                    m.t  = 1'b1;
                    m.hi = 0;
                    m.lo = 0;
                    inc  = 1'b1;
                end
            end else begin
                m.lo = s ? 0 : m.lo + 1;
                if (m.lo == HOLD) begin
                    m.t  = 1'b0;
                    m.lo = 0;
                    m.hi = 0;
                end
            end
            if (clr) m.veh = 0;
            else if (inc && m.veh < VMAX) m.veh = m.veh + 1;
        end
    endfunction

    // Drive one cycle, push the model's prediction, compare after the edge.
    task automatic step(input logic r, input logic a, input logic b, input logic c);
        exp_t e;
        reset = r; raw_a = a; raw_b = b; cnt_clr = c;
        model_step(ma, a, r, c);
        model_step(mb, b, r, c);
        sb_q.push_back('{ma.t, mb.t, ma.veh, mb.veh});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            check("sb_Ta", int'(Ta), int'(e.ta));
            check("sb_Tb", int'(Tb), int'(e.tb));
            check("sb_veh_a", int'(veh_a), e.va);
            check("sb_veh_b", int'(veh_b), e.vb);
        end
    endtask

    initial begin
        reset = 1'b1; raw_a = 1'b0; raw_b = 1'b0; cnt_clr = 1'b0;

        //           rst  a    b    clr  n   Ta   Tb   va vb
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 5, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 9, 1'b1, 1'b1, 1, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1, 1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0, 1, 1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 2, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 7, 1'b1, 1'b0, 2, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 2, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 2, 1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 6, 1'b1, 1'b0, 3, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b0, 3, 1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 5, 1'b1, 1'b0, 3, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 9, 1'b1, 1'b0, 3, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 3, 1});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 6, 1'b1, 1'b1, 4, 2});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 9, 1'b1, 1'b1, 4, 2});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 4, 2});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 6, 1'b1, 1'b0, 5, 2});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 7, 1'b1, 1'b0, 5, 2});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b0, 5, 2});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0, 5, 2});

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            repeat (vecs[i].n) step(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].clr);
            check($sformatf("vec%0d_Ta", i), int'(Ta), int'(vecs[i].ta));
            check($sformatf("vec%0d_Tb", i), int'(Tb), int'(vecs[i].tb));
            check($sformatf("vec%0d_veh_a", i), int'(veh_a), vecs[i].va);
            check($sformatf("vec%0d_veh_b", i), int'(veh_b), vecs[i].vb);
        end

        // Saturation: 255 arrivals reach the maximum, a 256th does not wrap.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_veh_a", int'(veh_a), 0);
        for (int k = 0; k < VMAX; k++) begin
            repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0);
            repeat (12) step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("sat_255", int'(veh_a), 255);
        repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (12) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_no_wrap", int'(veh_a), 255);

        // Clear on the qualifying edge beats the increment.
        repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("clr_pre_Ta", int'(Ta), 0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("clr_Ta", int'(Ta), 1);
        check("clr_veh_a", int'(veh_a), 0);

        // Reset while in GAP aborts it; re-qualification takes the full latency.
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("gap_Ta", int'(Ta), 1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("gap_rst_Ta", int'(Ta), 0);
        repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("requal_early_Ta", int'(Ta), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("requal_Ta", int'(Ta), 1);
        check("requal_veh_a", int'(veh_a), 1);

        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
